// File: rtl/lif_membrane_update_pkg.sv
// rtl/lif_membrane_update_pkg.sv - shared types, default widths and limits for the LIF membrane stage
//
// Contents:
//   N_STAGE_DEF, LS_W_DEF, REF_W_DEF : default parameter values
//   lif_state_t                      : membrane FSM state (ST_ACTIVE / ST_REFRAC)
//   lif_umax()                       : largest unsigned value of a given width

package lif_membrane_update_pkg;

  localparam int N_STAGE_DEF = 2;
  localparam int LS_W_DEF    = 2;
  localparam int REF_W_DEF   = 4;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_REFRAC = 1'b1
  } lif_state_t;

  function automatic int lif_umax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/lif_sat_acc.sv
// rtl/lif_sat_acc.sv - signed adder that clamps its result into [lo, hi]
//
// Ports:
//   a, b   in  W  signed operands
//   lo, hi in  W  signed clamp limits (lo <= hi)
//   y      out W  clamp(a + b, lo, hi)
//
// The sum is formed one bit wider so the raw result can never wrap before
// it is compared against the limits.

module lif_sat_acc #(
  parameter int W = 6
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  output logic signed [W-1:0] y
);

  logic signed [W:0] sum;
  logic signed [W:0] lo_x;
  logic signed [W:0] hi_x;

  assign sum  = $signed({a[W-1], a}) + $signed({b[W-1], b});
  assign lo_x = $signed({lo[W-1], lo});
  assign hi_x = $signed({hi[W-1], hi});

  always_comb begin
    y = sum[W-1:0];
    if (sum < lo_x) begin
      y = lo;
    end else if (sum > hi_x) begin
      y = hi;
    end
  end

endmodule

// File: rtl/lif_membrane_update.sv
// rtl/lif_membrane_update.sv - LIF membrane potential update with leak, reset and refractory period
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   step              timestep strobe (1-cycle pulse)
//   syn_valid/syn_w/syn_inh  synaptic event, weight magnitude, inhibitory flag
//   theta             firing threshold
//   leak_shift        leak = u >> leak_shift, 0 disables leak
//   reset_mode        0 = reset to zero after spike, 1 = subtract theta
//   refrac_period     timesteps held after a spike
//   is_spike          fire decision from spike_generator (combinational on u)
//   u                 registered membrane potential
//   minus_teta        two's complement of theta for spike_generator
//   spike_out         1-cycle pulse after a firing step
//   refractory        high while in the refractory state

module lif_membrane_update
  import lif_membrane_update_pkg::*;
#(
  parameter int n_stage = N_STAGE_DEF,
  parameter int LS_W    = LS_W_DEF,
  parameter int REF_W   = REF_W_DEF,
  localparam int U_W    = n_stage + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             syn_valid,
  input  logic [U_W-1:0]   syn_w,
  input  logic             syn_inh,
  input  logic [U_W-1:0]   theta,
  input  logic [LS_W-1:0]  leak_shift,
  input  logic             reset_mode,
  input  logic [REF_W-1:0] refrac_period,
  input  logic             is_spike,
  output logic [U_W-1:0]   u,
  output logic [U_W-1:0]   minus_teta,
  output logic             spike_out,
  output logic             refractory
);

  // acc needs U_W+1 magnitude bits plus sign; the u update needs one more
  // so u - leak + acc (range -UMAX..2*UMAX) is exact before clamping.
  localparam int A_W  = U_W + 2;
  localparam int X_W  = U_W + 3;
  localparam int UMAX = lif_umax(U_W);

  localparam logic signed [A_W-1:0] ACC_HI = A_W'(UMAX);
  localparam logic signed [A_W-1:0] ACC_LO = A_W'(-UMAX);
  localparam logic signed [X_W-1:0] U_HI   = X_W'(UMAX);
  localparam logic signed [X_W-1:0] U_LO   = '0;

  lif_state_t          state;
  lif_state_t          step_state;
  logic signed [A_W-1:0] acc;
  logic [REF_W-1:0]    ref_cnt;

  logic signed [A_W-1:0] ev_w;
  logic signed [A_W-1:0] acc_sum;
  logic [U_W-1:0]      leak;
  logic [U_W-1:0]      base;
  logic signed [X_W-1:0] base_x;
  logic signed [X_W-1:0] acc_x;
  logic signed [X_W-1:0] u_upd;
  logic                unused_u_hi;

  assign minus_teta = ~theta + 1'b1;

  always_comb begin
    ev_w = $signed({2'b00, syn_w});
    if (syn_inh) begin
      ev_w = -ev_w;
    end
  end

  lif_sat_acc #(.W(A_W)) u_acc_add (
    .a  (acc),
    .b  (ev_w),
    .lo (ACC_LO),
    .hi (ACC_HI),
    .y  (acc_sum)
  );

  // u >= leak always holds, so base never underflows.
  always_comb begin
    leak = '0;
    if (leak_shift != '0) begin
      leak = u >> leak_shift;
    end
  end

  assign base   = u - leak;
  assign base_x = $signed({3'b000, base});
  assign acc_x  = $signed({acc[A_W-1], acc});

  lif_sat_acc #(.W(X_W)) u_mem_add (
    .a  (base_x),
    .b  (acc_x),
    .lo (U_LO),
    .hi (U_HI),
    .y  (u_upd)
  );

  // Clamped to [0, UMAX], so the upper bits are always zero.
  assign unused_u_hi = ^u_upd[X_W-1:U_W];

  // State the neuron will be in after the current step.
  always_comb begin
    step_state = state;
    case (state)
      ST_ACTIVE: if (is_spike && refrac_period != '0) step_state = ST_REFRAC;
      ST_REFRAC: if (ref_cnt <= REF_W'(1)) step_state = ST_ACTIVE;
      default:   step_state = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ACTIVE;
      u          <= '0;
      acc        <= '0;
      ref_cnt    <= '0;
      spike_out  <= 1'b0;
      refractory <= 1'b0;
    end else begin
      spike_out <= 1'b0;
      if (step) begin
        case (state)
          ST_ACTIVE: begin
            if (is_spike) begin
              u         <= reset_mode ? (u - theta) : '0;
              spike_out <= 1'b1;
              ref_cnt   <= refrac_period;
            end else begin
              u <= u_upd[U_W-1:0];
            end
          end
          ST_REFRAC: ref_cnt <= ref_cnt - 1'b1;
          default:   ref_cnt <= '0;
        endcase
        state      <= step_state;
        refractory <= (step_state == ST_REFRAC);
        // A same-cycle event opens the next timestep, unless that timestep is refractory.
        acc <= (step_state == ST_ACTIVE && syn_valid) ? ev_w : '0;
      end else if (syn_valid && state == ST_ACTIVE) begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_lif_membrane_update.sv
// tb/tb_lif_membrane_update.sv - directed self-checking bench for lif_membrane_update

module tb_lif_membrane_update;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic       syn_valid = 1'b0;
  logic [3:0] syn_w = '0;
  logic       syn_inh = 1'b0;
  logic [3:0] theta = 4'd8;
  logic [1:0] leak_shift = 2'd1;
  logic       reset_mode = 1'b1;
  logic [3:0] refrac_period = 4'd2;
  logic       is_spike;
  logic [3:0] u;
  logic [3:0] minus_teta;
  logic       spike_out;
  logic       refractory;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // spike_generator: fires when u reaches theta
  assign is_spike = (u >= theta);

  lif_membrane_update #(.n_stage(2), .LS_W(2), .REF_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .step          (step),
    .syn_valid     (syn_valid),
    .syn_w         (syn_w),
    .syn_inh       (syn_inh),
    .theta         (theta),
    .leak_shift    (leak_shift),
    .reset_mode    (reset_mode),
    .refrac_period (refrac_period),
    .is_spike      (is_spike),
    .u             (u),
    .minus_teta    (minus_teta),
    .spike_out     (spike_out),
    .refractory    (refractory)
  );

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic ev(input int w, input bit inh);
    syn_valid = 1'b1;
    syn_w     = 4'(w);
    syn_inh   = inh;
    tick();
    syn_valid = 1'b0;
    syn_inh   = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    // T1 reset and minus_teta
    do_reset();
    check("rst_u", int'(u), 0);
    check("rst_spike", int'(spike_out), 0);
    check("rst_refr", int'(refractory), 0);
    check("mteta_8", int'(minus_teta), 8);
    theta = 4'd3;
    #1;
    check("mteta_3", int'(minus_teta), 13);
    theta = 4'd8;
    #1;

    // T2 accumulate and leak
    ev(3, 0);
    ev(4, 0);
    do_step();
    check("t2_acc", int'(u), 7);
    check("t2_nospike", int'(spike_out), 0);
    do_step();
    check("t2_leak", int'(u), 4);
    do_reset();
    ev(3, 0);
    ev(4, 0);
    do_step();
    leak_shift = 2'd0;
    do_step();
    check("t2_noleak", int'(u), 7);
    leak_shift = 2'd1;

    // T3 spike, refractory, subtract-theta reset
    do_reset();
    ev(10, 0);
    do_step();
    check("t3_u10", int'(u), 10);
    do_step();
    check("t3_sub", int'(u), 2);
    check("t3_spike", int'(spike_out), 1);
    check("t3_refr", int'(refractory), 1);
    tick();
    check("t3_spike_pulse", int'(spike_out), 0);
    ev(5, 0);
    do_step();
    check("t3_hold1", int'(u), 2);
    check("t3_refr1", int'(refractory), 1);
    ev(5, 0);
    do_step();
    check("t3_hold2", int'(u), 2);
    check("t3_refr_end", int'(refractory), 0);
    ev(5, 0);
    do_step();
    check("t3_resume", int'(u), 6);
    // zero-reset mode
    reset_mode = 1'b0;
    do_reset();
    ev(10, 0);
    do_step();
    do_step();
    check("t3_zero", int'(u), 0);
    check("t3_zero_spike", int'(spike_out), 1);
    reset_mode = 1'b1;

    // T4 u saturation (high threshold keeps the neuron silent)
    theta = 4'd15;
    do_reset();
    ev(12, 0);
    do_step();
    check("t4_u12", int'(u), 12);
    ev(9, 0);
    do_step();
    check("t4_sat_hi", int'(u), 15);
    do_reset();
    ev(4, 0);
    do_step();
    ev(9, 1);
    do_step();
    check("t4_sat_lo", int'(u), 0);

    // T5 acc saturation: +15 x20 then -15 must land at 0
    do_reset();
    for (int i = 0; i < 20; i++) ev(15, 0);
    ev(15, 1);
    do_step();
    check("t5_acc_cancel", int'(u), 0);
    for (int i = 0; i < 20; i++) ev(15, 0);
    do_step();
    check("t5_acc_sat", int'(u), 15);
    theta = 4'd8;

    // T6 same-cycle event goes to next timestep
    do_reset();
    ev(6, 0);
    do_step();
    syn_valid = 1'b1;
    syn_w     = 4'd3;
    step      = 1'b1;
    tick();
    syn_valid = 1'b0;
    step      = 1'b0;
    check("t6_excl", int'(u), 3);
    do_step();
    check("t6_incl", int'(u), 5);
    // rst mid-REFRAC
    do_reset();
    ev(10, 0);
    do_step();
    do_step();
    check("t6_in_refr", int'(refractory), 1);
    do_reset();
    check("t6_rst_u", int'(u), 0);
    check("t6_rst_spike", int'(spike_out), 0);
    check("t6_rst_refr", int'(refractory), 0);
    ev(3, 0);
    do_step();
    check("t6_active", int'(u), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
